apb_master_bridge: RTL and testbench



---
 rtl/apb_master_bridge.sv | 182 ++++++++++++++++++
 tb/tb_apb_master_bridge.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_bridge
// Purpose  : CPU request bus to APB initiator. Decodes the peripheral region
//            into a one-hot PSEL, sequences SETUP/ACCESS, and returns a
//            one-cycle ready pulse with read data and an error flag.
// Options  : APB_TIMEOUT_EN - abort an ACCESS phase after TIMEOUT_CYC
//            wait cycles with err=1.
// Revision : 1.0 - initial release
// ============================================================================
module apb_master_bridge #(
  parameter int          NUM_SLV     = 4,
  parameter logic [15:0] BASE_HI     = 16'h1000,
  parameter int          TIMEOUT_CYC = 255
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  req,
  input  logic                  we,
  input  logic [31:0]           addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic                  ready,
  output logic                  err,
  output logic [31:0]           PADDR,
  output logic                  PWRITE,
  output logic [31:0]           PWDATA,
  output logic                  PENABLE,
  output logic [NUM_SLV-1:0]    PSEL,
  input  logic [NUM_SLV*32-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]    PREADY
);

  // Reject unsupported configurations at elaboration time.
  if (NUM_SLV < 1 || NUM_SLV > 16 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("apb_master_bridge: NUM_SLV must be 1..16 and TIMEOUT_CYC >= 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t               state_q,   state_d;
  logic [31:0]          paddr_q,   paddr_d;
  logic                 pwrite_q,  pwrite_d;
  logic [31:0]          pwdata_q,  pwdata_d;
  logic                 penable_q, penable_d;
  logic [NUM_SLV-1:0]   psel_q,    psel_d;
  logic [31:0]          rdata_q,   rdata_d;
  logic                 ready_q,   ready_d;
  logic                 err_q,     err_d;

`ifdef APB_TIMEOUT_EN
  // At least 8 bits, wider only if the limit needs it.
  localparam int CNT_W = (TIMEOUT_CYC > 255) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [CNT_W-1:0]     wait_cnt_q, wait_cnt_d;
`endif

  logic                 hit;
  logic [NUM_SLV-1:0]   psel_dec;
  logic                 pready_sel;
  logic [31:0]          prdata_sel;

  // Address decode and selected-slave response mux; PSEL is already one-hot,
  // so it doubles as the mux select and no separate index register is kept.
  always_comb begin
    hit        = (addr[31:16] == BASE_HI) && (32'(addr[15:12]) < 32'(NUM_SLV));
    psel_dec   = '0;
    prdata_sel = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      psel_dec[i] = (addr[15:12] == 4'(i));
      if (psel_q[i]) prdata_sel = prdata_sel | PRDATA[32*i +: 32];
    end
    pready_sel = |(psel_q & PREADY);
  end

  // Next-state and next-output computation for the SETUP/ACCESS sequencer.
  always_comb begin
    state_d   = state_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    penable_d = penable_q;
    psel_d    = psel_q;
    rdata_d   = '0;
    ready_d   = 1'b0;
    err_d     = 1'b0;
`ifdef APB_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        // ready_q blocks a level-held req from being taken twice.
        if (req && !ready_q) begin
          paddr_d  = addr;
          pwrite_d = we;
          pwdata_d = wdata;
          if (hit) begin
            psel_d  = psel_dec;
            state_d = SETUP;
          end else begin
            ready_d = 1'b1;
            err_d   = 1'b1;
          end
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
`ifdef APB_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      ACCESS: begin
        if (pready_sel) begin
          psel_d    = '0;
          penable_d = 1'b0;
          ready_d   = 1'b1;
          rdata_d   = pwrite_q ? 32'd0 : prdata_sel;
          state_d   = IDLE;
        end
`ifdef APB_TIMEOUT_EN
        // This stall cycle is the one that brings the count to TIMEOUT_CYC.
        else if (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          psel_d    = '0;
          penable_d = 1'b0;
          ready_d   = 1'b1;
          err_d     = 1'b1;
          state_d   = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // All state and outputs registered; PRESET clears everything asynchronously.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q    <= IDLE;
      paddr_q    <= '0;
      pwrite_q   <= 1'b0;
      pwdata_q   <= '0;
      penable_q  <= 1'b0;
      psel_q     <= '0;
      rdata_q    <= '0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
`ifdef APB_TIMEOUT_EN
      wait_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      paddr_q    <= paddr_d;
      pwrite_q   <= pwrite_d;
      pwdata_q   <= pwdata_d;
      penable_q  <= penable_d;
      psel_q     <= psel_d;
      rdata_q    <= rdata_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
`ifdef APB_TIMEOUT_EN
      wait_cnt_q <= wait_cnt_d;
`endif
    end
  end

  assign PADDR   = paddr_q;
  assign PWRITE  = pwrite_q;
  assign PWDATA  = pwdata_q;
  assign PENABLE = penable_q;
  assign PSEL    = psel_q;
  assign rdata   = rdata_q;
  assign ready   = ready_q;
  assign err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_master_bridge
// Purpose  : Self-checking bench for apb_master_bridge: directed table,
//            randomized transfers against a latency/data model, back-to-back,
//            mid-transfer reset and stalled-slave behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_master_bridge;

  localparam int NUM_SLV = 4;
  localparam int TO_CYC  = 4;

  logic                  PCLK = 1'b0;
  logic                  PRESET;
  logic                  req, we;
  logic [31:0]           addr, wdata;
  logic [31:0]           rdata;
  logic                  ready, err;
  logic [31:0]           PADDR;
  logic                  PWRITE;
  logic [31:0]           PWDATA;
  logic                  PENABLE;
  logic [NUM_SLV-1:0]    PSEL;
  logic [NUM_SLV*32-1:0] PRDATA;
  logic [NUM_SLV-1:0]    PREADY;

  apb_master_bridge #(
    .NUM_SLV    (NUM_SLV),
    .BASE_HI    (16'h1000),
    .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .req    (req),
    .we     (we),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .ready  (ready),
    .err    (err),
    .PADDR  (PADDR),
    .PWRITE (PWRITE),
    .PWDATA (PWDATA),
    .PENABLE(PENABLE),
    .PSEL   (PSEL),
    .PRDATA (PRDATA),
    .PREADY (PREADY)
  );

  always #5 PCLK = ~PCLK;

  // Slave models: fixed read data, PREADY after wait_cfg stalled ACCESS cycles.
  logic [31:0] slv_data [NUM_SLV];
  int          wait_cfg [NUM_SLV];
  int          wcnt     [NUM_SLV];

  always_comb begin
    for (int i = 0; i < NUM_SLV; i++) begin
      PRDATA[32*i +: 32] = slv_data[i];
      PREADY[i]          = PSEL[i] && PENABLE && (wcnt[i] >= wait_cfg[i]);
    end
  end

  always @(posedge PCLK) begin
    for (int i = 0; i < NUM_SLV; i++) begin
      if (PSEL[i] && PENABLE && !PREADY[i]) wcnt[i] <= wcnt[i] + 1;
      else                                  wcnt[i] <= 0;
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one transfer; returns latency in cycles after acceptance (-1 if
  // no ready within bound), the returned data/error, and whether the APB
  // side behaved as the address decode dictates throughout.
  task automatic run_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input int waits, input int bound,
                         output int lat, output logic [31:0] rd, output logic e,
                         output logic prot_ok);
    logic               hit;
    int                 idx;
    logic [NUM_SLV-1:0] exp_sel;
    idx     = int'(a[15:12]);
    hit     = (a[31:16] == 16'h1000) && (idx < NUM_SLV);
    exp_sel = '0;
    if (hit) exp_sel[idx] = 1'b1;
    for (int i = 0; i < NUM_SLV; i++) wait_cfg[i] = waits;
    @(negedge PCLK);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge PCLK); #1;
    // Scramble inputs after acceptance; the bridge must ignore them.
    req = 1'b0; addr = $urandom; wdata = $urandom; we = 1'($urandom);
    lat = 1; prot_ok = 1'b1;
    while (!ready && lat < bound) begin
      if (PSEL !== exp_sel || PADDR !== a || PWDATA !== d || PWRITE !== w) prot_ok = 1'b0;
      if (PENABLE !== (lat >= 2)) prot_ok = 1'b0;
      @(posedge PCLK); #1;
      lat++;
    end
    rd = rdata; e = err;
    if (ready !== 1'b1) lat = -1;
    else if (PSEL !== '0 || PENABLE !== 1'b0 || PADDR !== a) prot_ok = 1'b0;
    @(posedge PCLK); #1;
    if (ready !== 1'b0 || rdata !== 32'd0 || err !== 1'b0) prot_ok = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    int          waits;
    int          exp_lat;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        e, pok;

    PRESET = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      wait_cfg[i] = 0; wcnt[i] = 0;
    end
    slv_data[0] = 32'hA000_0000;
    slv_data[1] = 32'h3132_3334;
    slv_data[2] = 32'h2222_2222;
    slv_data[3] = 32'hDEAD_BEEF;

    vecs[0] = '{"wr_slv0_zero_wait", 1'b1, 32'h1000_0000, 32'h0000_0001, 0, 3, 32'h0,         1'b0};
    vecs[1] = '{"rd_slv1_2wait",     1'b0, 32'h1000_1014, 32'h0,         2, 5, 32'h3132_3334, 1'b0};
    vecs[2] = '{"rd_region_miss",    1'b0, 32'h2000_0000, 32'h0,         0, 1, 32'h0,         1'b1};
    vecs[3] = '{"rd_idx_too_big",    1'b0, 32'h1000_5000, 32'h0,         0, 1, 32'h0,         1'b1};
    vecs[4] = '{"rd_slv3_1wait",     1'b0, 32'h1000_3FFC, 32'h0,         1, 4, 32'hDEAD_BEEF, 1'b0};
    vecs[5] = '{"wr_slv2_3wait",     1'b1, 32'h1000_2008, 32'hCAFE_F00D, 3, 6, 32'h0,         1'b0};
    vecs[6] = '{"wr_hi_miss",        1'b1, 32'h1001_0000, 32'h1234_5678, 0, 1, 32'h0,         1'b1};

    // Reset values.
    repeat (3) @(posedge PCLK);
    #1;
    chk("rst_ready",   32'(ready),   32'd0);
    chk("rst_err",     32'(err),     32'd0);
    chk("rst_rdata",   rdata,        32'd0);
    chk("rst_psel",    32'(PSEL),    32'd0);
    chk("rst_penable", 32'(PENABLE), 32'd0);
    chk("rst_paddr",   PADDR,        32'd0);
    chk("rst_pwdata",  PWDATA,       32'd0);
    chk("rst_pwrite",  32'(PWRITE),  32'd0);
    @(negedge PCLK);
    PRESET = 1'b0;

    // Directed table.
    for (int v = 0; v < 7; v++) begin
      run_txn(vecs[v].w, vecs[v].a, vecs[v].d, vecs[v].waits, 50, lat, rd, e, pok);
      chk({vecs[v].name, "_lat"},   32'(lat), 32'(vecs[v].exp_lat));
      chk({vecs[v].name, "_rdata"}, rd,       vecs[v].exp_rd);
      chk({vecs[v].name, "_err"},   32'(e),   32'(vecs[v].exp_err));
      chk({vecs[v].name, "_apb"},   32'(pok), 32'd1);
    end

    // Randomized transfers against a latency/data model.
    for (int t = 0; t < 40; t++) begin
      logic        w, hit;
      logic [31:0] a, d, exp_rd;
      int          waits, idx, exp_lat;
      logic        exp_err;
      for (int i = 0; i < NUM_SLV; i++) slv_data[i] = $urandom;
      w     = 1'($urandom);
      d     = $urandom;
      idx   = $urandom_range(0, 7);
      a     = {(($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h1000), 4'(idx), 12'($urandom)};
      waits = $urandom_range(0, 3);
      hit   = (a[31:16] == 16'h1000) && (idx < NUM_SLV);
      exp_lat = hit ? 3 + waits : 1;
      exp_err = !hit;
      exp_rd  = (hit && !w) ? slv_data[idx] : 32'd0;
      run_txn(w, a, d, waits, 50, lat, rd, e, pok);
      chk("rand_lat",   32'(lat), 32'(exp_lat));
      chk("rand_rdata", rd,       exp_rd);
      chk("rand_err",   32'(e),   32'(exp_err));
      chk("rand_apb",   32'(pok), 32'd1);
    end

    // Level-held req: one transfer per ready, next SETUP 4 cycles later.
    begin
      int n_setup, s1, s2, nr, r1, r2;
      logic bad;
      n_setup = 0; s1 = 0; s2 = 0; nr = 0; r1 = 0; r2 = 0; bad = 1'b0;
      for (int i = 0; i < NUM_SLV; i++) wait_cfg[i] = 0;
      @(negedge PCLK);
      req = 1'b1; we = 1'b1; addr = 32'h1000_0000; wdata = 32'h55;
      for (int c = 1; c <= 8; c++) begin
        @(posedge PCLK); #1;
        if (PSEL != '0 && !PENABLE) begin
          n_setup++;
          if (n_setup == 1) s1 = c; else if (n_setup == 2) s2 = c;
          if (ready) bad = 1'b1;
        end
        if (ready) begin
          nr++;
          if (nr == 1) r1 = c; else if (nr == 2) r2 = c;
        end
      end
      req = 1'b0;
      repeat (4) @(posedge PCLK);
      #1;
      chk("b2b_setup_count", 32'(n_setup), 32'd2);
      chk("b2b_setup1",      32'(s1),      32'd1);
      chk("b2b_setup2",      32'(s2),      32'd5);
      chk("b2b_ready_count", 32'(nr),      32'd2);
      chk("b2b_ready1",      32'(r1),      32'd3);
      chk("b2b_ready2",      32'(r2),      32'd7);
      chk("b2b_setup_in_ready", 32'(bad),  32'd0);
    end

    // PRESET during a stalled ACCESS.
    begin
      int nr;
      nr = 0;
      for (int i = 0; i < NUM_SLV; i++) wait_cfg[i] = 100000;
      @(negedge PCLK);
      req = 1'b1; we = 1'b0; addr = 32'h1000_2000;
      @(posedge PCLK); #1;
      req = 1'b0;
      repeat (3) @(posedge PCLK);
      #1;
      chk("rst_mid_in_access", 32'(PENABLE), 32'd1);
      @(negedge PCLK);
      PRESET = 1'b1;
      #1;
      chk("rst_mid_psel",    32'(PSEL),    32'd0);
      chk("rst_mid_penable", 32'(PENABLE), 32'd0);
      chk("rst_mid_paddr",   PADDR,        32'd0);
      chk("rst_mid_ready",   32'(ready),   32'd0);
      @(posedge PCLK);
      @(negedge PCLK);
      PRESET = 1'b0;
      for (int c = 0; c < 6; c++) begin
        @(posedge PCLK); #1;
        if (ready) nr++;
      end
      chk("rst_mid_no_ready", 32'(nr), 32'd0);
      run_txn(1'b0, 32'h1000_2004, 32'h0, 0, 50, lat, rd, e, pok);
      chk("post_rst_lat",   32'(lat), 32'd3);
      chk("post_rst_rdata", rd,       slv_data[2]);
      chk("post_rst_err",   32'(e),   32'd0);
    end

    // Slave stuck with PREADY low.
`ifdef APB_TIMEOUT_EN
    run_txn(1'b0, 32'h1000_0000, 32'h0, 100000, 50, lat, rd, e, pok);
    chk("timeout_lat",   32'(lat), 32'(2 + TO_CYC));
    chk("timeout_rdata", rd,       32'd0);
    chk("timeout_err",   32'(e),   32'd1);
    chk("timeout_apb",   32'(pok), 32'd1);
`else
    run_txn(1'b0, 32'h1000_0000, 32'h0, 100000, 1000, lat, rd, e, pok);
    chk("stall_no_ready",  32'(lat),     32'hFFFF_FFFF);
    chk("stall_penable",   32'(PENABLE), 32'd1);
    chk("stall_psel",      32'(PSEL),    32'd1);
    @(negedge PCLK);
    PRESET = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
